// File: rtl/alu_ctrl_issue.sv
// ID/EX issue register for the ALU: decodes ALUOp/opcode/funct into the 4-bit ALU control code
// and holds it with the operands behind a valid/ready handshake. Optional macro: ALU_ILLEGAL_CNT_EN.
module alu_ctrl_issue #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_illegal,
  output logic              err_sticky,
  output logic [7:0]        illegal_cnt
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_BAD = 4'b1111;

  // Returns {illegal, ctrl}; anything outside the table maps to 1111 so the ALU yields zero.
  function automatic logic [4:0] decode_ctrl(input logic [1:0] aluop,
                                             input logic [5:0] opcode,
                                             input logic [5:0] funct);
    logic [4:0] res;
    res = {1'b1, CTRL_BAD};
    case (aluop)
      2'b00: res = {1'b0, CTRL_ADD};
      2'b01: res = {1'b0, CTRL_SUB};
      2'b10: begin
        case (funct)
          6'b100000: res = {1'b0, CTRL_ADD};
          6'b100010: res = {1'b0, CTRL_SUB};
          6'b100100: res = {1'b0, CTRL_AND};
          6'b100101: res = {1'b0, CTRL_OR};
          6'b101010: res = {1'b0, CTRL_SLT};
          6'b001000: res = {1'b0, CTRL_ADD};
          default:   res = {1'b1, CTRL_BAD};
        endcase
      end
      2'b11: begin
        case (opcode)
          6'b001000: res = {1'b0, CTRL_ADD};
          6'b001100: res = {1'b0, CTRL_AND};
          6'b001101: res = {1'b0, CTRL_OR};
          6'b001010: res = {1'b0, CTRL_SLT};
          default:   res = {1'b1, CTRL_BAD};
        endcase
      end
      default: res = {1'b1, CTRL_BAD};
    endcase
    return res;
  endfunction

  logic              out_valid_r;
  logic [3:0]        out_alu_ctrl_r;
  logic [DATA_W-1:0] out_a_r;
  logic [DATA_W-1:0] out_b_r;
  logic [REG_W-1:0]  out_rd_r;
  logic              out_illegal_r;
  logic              err_sticky_r;
  logic              dec_illegal_s;
  logic [3:0]        dec_ctrl_s;
  logic              accept_s;
  logic              complete_s;
  logic              illegal_done_s;

  assign {dec_illegal_s, dec_ctrl_s} = decode_ctrl(in_aluop, in_opcode, in_funct);
  assign in_ready       = !out_valid_r || out_ready;
  assign accept_s       = in_valid && in_ready;
  // A flushed entry never completes, so a killed illegal instruction is not reported.
  assign complete_s     = out_valid_r && out_ready && !flush;
  assign illegal_done_s = complete_s && out_illegal_r;

  // Issue register: flush wins over accept, accept wins over drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r    <= 1'b0;
      out_alu_ctrl_r <= 4'b0000;
      out_a_r        <= '0;
      out_b_r        <= '0;
      out_rd_r       <= '0;
      out_illegal_r  <= 1'b0;
    end else if (flush) begin
      out_valid_r    <= 1'b0;
      out_illegal_r  <= 1'b0;
    end else if (accept_s) begin
      out_valid_r    <= 1'b1;
      out_alu_ctrl_r <= dec_ctrl_s;
      out_a_r        <= in_a;
      out_b_r        <= in_b;
      out_rd_r       <= in_rd;
      out_illegal_r  <= dec_illegal_s;
    end else if (complete_s) begin
      out_valid_r    <= 1'b0;
    end else begin
      out_valid_r    <= out_valid_r;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_r <= 1'b0;
    end else if (illegal_done_s) begin
      err_sticky_r <= 1'b1;
    end else begin
      err_sticky_r <= err_sticky_r;
    end
  end

`ifdef ALU_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt_r;

  // Saturating count of completed illegal instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt_r <= 8'h00;
    end else if (illegal_done_s && (illegal_cnt_r != 8'hFF)) begin
      illegal_cnt_r <= illegal_cnt_r + 8'h01;
    end else begin
      illegal_cnt_r <= illegal_cnt_r;
    end
  end

  assign illegal_cnt = illegal_cnt_r;
`else
  assign illegal_cnt = 8'h00;
`endif

  assign out_valid    = out_valid_r;
  assign out_alu_ctrl = out_alu_ctrl_r;
  assign out_a        = out_a_r;
  assign out_b        = out_b_r;
  assign out_rd       = out_rd_r;
  assign out_illegal  = out_illegal_r;
  assign err_sticky   = err_sticky_r;

endmodule
